// File: rtl/fetch_unit.sv
// fetch_unit: four-state instruction fetch FSM with branch redirect, stall hold and flush kill.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_four_i,
    input  logic        br_sel_i,
    input  logic [31:0] alu_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {RST_S, REQ_S, WAIT_S, VALID_S} state_t;
    state_t      state, state_n;
    logic [31:0] pc_n, instr_n;
    logic        kill, kill_n, mis_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= RST_S;
            pc_o       <= RESET_PC;
            instr_o    <= '0;
            kill       <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_n;
            pc_o       <= pc_n;
            instr_o    <= instr_n;
            kill       <= kill_n;
            misalign_o <= mis_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_o;
        instr_n = instr_o;
        kill_n  = kill;
        mis_n   = 1'b0;
        case (state)
            RST_S:   state_n = REQ_S;
            REQ_S:   state_n = imem_gnt_i ? WAIT_S : REQ_S;
            WAIT_S: begin
                if (imem_rvalid_i) begin
                    state_n = kill ? REQ_S : VALID_S;
                    instr_n = kill ? instr_o : imem_rdata_i;
                    kill_n  = 1'b0;
                end
            end
            VALID_S: begin
                if (!stall_i) begin
                    state_n = REQ_S;
                    pc_n    = br_sel_i ? {alu_data_i[31:2], 2'b00} : pc_four_i;
                    mis_n   = br_sel_i & |alu_data_i[1:0];
                end
            end
            default: state_n = RST_S;
        endcase
        // A flush may land while a grant is outstanding; the kill flag drops that response.
        if (flush_i) begin
            pc_n    = {flush_pc_i[31:2], 2'b00};
            mis_n   = |flush_pc_i[1:0];
            instr_n = instr_o;
            case (state)
                REQ_S: begin
                    state_n = imem_gnt_i ? WAIT_S : REQ_S;
                    kill_n  = imem_gnt_i;
                end
                WAIT_S: begin
                    state_n = imem_rvalid_i ? REQ_S : WAIT_S;
                    kill_n  = !imem_rvalid_i;
                end
                default: begin
                    state_n = REQ_S;
                    kill_n  = 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = state == REQ_S;
    assign imem_addr_o   = pc_o;
    assign instr_valid_o = state == VALID_S;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks drive the fetch unit; a monitor pops expected {pc,instr} on each new valid.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc_four, alu_data, flush_pc, pc, addr, rdata, instr;
    logic        br_sel, stall, flush, req, gnt, rvalid, valid, mis;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_four_i(pc_four), .br_sel_i(br_sel),
        .alu_data_i(alu_data), .stall_i(stall), .flush_i(flush), .flush_pc_i(flush_pc),
        .pc_o(pc), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .instr_o(instr),
        .instr_valid_o(valid), .misalign_o(mis)
    );

    always #5 clk = ~clk;
    assign pc_four = pc + 32'd4;

    always @(negedge clk) begin
        if (valid && !prev_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h, want no instruction", pc, instr);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({pc, instr} !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got pc %h instr %h want pc %h instr %h", pc, instr, e[63:32], e[31:0]);
                end
            end
        end
        prev_valid <= valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            gnt = 1'b0;
            checks++;
            if ({req, addr} !== {1'b1, exp_pc}) begin
                errors++;
                $display("FAIL gnt_hold: got req %b addr %h want req 1 addr %h", req, addr, exp_pc);
            end
            step();
        end
        checks++;
        if ({req, addr, valid} !== {1'b1, exp_pc, 1'b0}) begin
            errors++;
            $display("FAIL req_state: got req %b addr %h valid %b want 1 %h 0", req, addr, valid, exp_pc);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        checks++;
        if ({req, valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_state: got req %b valid %b want 0 0", req, valid);
        end
        rvalid = 1'b1;
        rdata = data;
        stall = 1'b1;
        sb.push_back({exp_pc, data});
        step();
        rvalid = 1'b0;
        checks++;
        if ({valid, instr} !== {1'b1, data}) begin
            errors++;
            $display("FAIL valid_state: got valid %b instr %h want 1 %h", valid, instr, data);
        end
    endtask

    task automatic advance(input logic b, input logic [31:0] t);
        logic exp_mis;
        stall = 1'b0;
        br_sel = b;
        alu_data = t;
        exp_pc = b ? {t[31:2], 2'b00} : exp_pc + 32'd4;
        exp_mis = b & |t[1:0];
        step();
        br_sel = 1'b0;
        checks++;
        if ({pc, addr, mis, valid, req} !== {exp_pc, exp_pc, exp_mis, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL advance: got pc %h addr %h mis %b valid %b req %b want pc %h mis %b valid 0 req 1",
                     pc, addr, mis, valid, req, exp_pc, exp_mis);
        end
        step();
        checks++;
        if ({mis, addr} !== {1'b0, exp_pc}) begin
            errors++;
            $display("FAIL mis_pulse: got mis %b addr %h want 0 %h", mis, addr, exp_pc);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, instr, valid, req, mis} !== {32'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset: got pc %h instr %h valid %b req %b mis %b want all 0", pc, instr, valid, req, mis);
        end
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL rst_state: got req %b want 0", req);
        end
        step();
        exp_pc = 32'h0;
    endtask

    task automatic test_basic();
        do_fetch(32'h0000_0013, 0);
        advance(1'b0, 32'h0);
    endtask

    task automatic test_branch();
        do_fetch(32'h0000_0293, 0);
        advance(1'b1, 32'h0000_0102);
    endtask

    task automatic test_stall();
        do_fetch(32'h1234_5678, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({valid, instr, pc, req} !== {1'b1, 32'h1234_5678, exp_pc, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got valid %b instr %h pc %h req %b want 1 12345678 %h 0", valid, instr, pc, req, exp_pc);
            end
        end
        advance(1'b0, 32'h0);
    endtask

    task automatic test_gnt_wait();
        do_fetch(32'hCAFE_0001, 4);
        advance(1'b0, 32'h0);
    endtask

    task automatic test_flush_wait();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        flush = 1'b1;
        flush_pc = 32'h0000_0080;
        step();
        flush = 1'b0;
        exp_pc = 32'h0000_0080;
        checks++;
        if ({valid, req, pc, mis} !== {2'b00, exp_pc, 1'b0}) begin
            errors++;
            $display("FAIL flush_wait: got valid %b req %b pc %h mis %b want 0 0 %h 0", valid, req, pc, mis, exp_pc);
        end
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        checks++;
        if ({valid, req, addr} !== {2'b01, exp_pc}) begin
            errors++;
            $display("FAIL flush_drop: got valid %b req %b addr %h want 0 1 %h", valid, req, addr, exp_pc);
        end
        do_fetch(32'h0000_0517, 0);
        advance(1'b0, 32'h0);
    endtask

    task automatic test_flush_misalign();
        do_fetch(32'h0000_0667, 0);
        flush = 1'b1;
        flush_pc = 32'h0000_0203;
        br_sel = 1'b1;
        alu_data = 32'h0000_0400;
        step();
        flush = 1'b0;
        br_sel = 1'b0;
        exp_pc = 32'h0000_0200;
        checks++;
        if ({pc, mis, req, valid} !== {exp_pc, 3'b110}) begin
            errors++;
            $display("FAIL flush_valid: got pc %h mis %b req %b valid %b want %h 1 1 0", pc, mis, req, valid, exp_pc);
        end
        step();
        checks++;
        if ({mis, addr} !== {1'b0, exp_pc}) begin
            errors++;
            $display("FAIL flush_mis_pulse: got mis %b addr %h want 0 %h", mis, addr, exp_pc);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        do_fetch(32'h0000_0001, 0);
        advance(1'b0, 32'h0);
    endtask

    task automatic test_rvalid_ignored();
        rvalid = 1'b1;
        rdata = 32'hBAD0_BAD0;
        step();
        rvalid = 1'b0;
        checks++;
        if ({req, valid, addr} !== {2'b10, exp_pc}) begin
            errors++;
            $display("FAIL rvalid_ignored: got req %b valid %b addr %h want 1 0 %h", req, valid, addr, exp_pc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'hA000_0000 + i, 0);
            advance(1'b0, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc, instr, valid, req, mis} !== {32'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid: got pc %h instr %h valid %b req %b mis %b want all 0", pc, instr, valid, req, mis);
        end
        rvalid = 1'b1;
        rdata = 32'hFEED_FACE;
        step();
        rst_n = 1'b1;
        step();
        rvalid = 1'b0;
        exp_pc = 32'h0;
        checks++;
        if ({req, valid, addr, instr} !== {2'b10, exp_pc, 32'h0}) begin
            errors++;
            $display("FAIL reset_restart: got req %b valid %b addr %h instr %h want 1 0 0 0", req, valid, addr, instr);
        end
        do_fetch(32'h0000_0093, 0);
        advance(1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        {br_sel, stall, flush, gnt, rvalid} = '0;
        {alu_data, flush_pc, rdata} = '0;
        exp_pc = 32'h0;
        test_reset();
        test_basic();
        test_branch();
        test_stall();
        test_gnt_wait();
        test_flush_wait();
        test_flush_misalign();
        test_wrap();
        test_rvalid_ignored();
        test_back_to_back();
        test_reset_mid();
        step();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 pc_four_i  input  32  sequential next PC (pc_o + 4) from the PC adder.
REQ-005 br_sel_i  input  1  1 = take branch/jump target on advance.
REQ-006 alu_data_i  input  32  branch/jump target.
REQ-007 stall_i  input  1  1 = consumer not ready; hold current instruction.
REQ-008 flush_i  input  1  asynchronous-to-pipeline redirect (trap/exception), any state.
REQ-009 flush_pc_i  input  32  redirect target for flush_i.
REQ-010 pc_o  output  32  current PC; drives the PC adder operand and imem_addr_o.
REQ-011 imem_req_o  output  1  instruction-memory request.
REQ-012 imem_addr_o  output  32  request address, equal to pc_o.
REQ-013 imem_gnt_i  input  1  memory accepted request this cycle.
REQ-014 imem_rvalid_i  input  1  read data valid this cycle.
REQ-015 imem_rdata_i  input  32  read data.
REQ-016 instr_o  output  32  fetched instruction.
REQ-017 instr_valid_o  output  1  instr_o valid for the instruction at pc_o.
REQ-018 misalign_o  output  1  one-cycle pulse: selected target had bits [1:0] != 0.

Function
REQ-019 FSM states SHALL be RST_S, REQ_S, WAIT_S, VALID_S, plus a 1-bit kill flag.
REQ-020 RST_S: imem_req_o=0; unconditional transition to REQ_S next cycle.
REQ-021 REQ_S: imem_req_o=1; imem_gnt_i=1 -> WAIT_S; else stay, address held stable.
REQ-022 WAIT_S: imem_req_o=0; on imem_rvalid_i with kill=0, capture imem_rdata_i into instr_o, -> VALID_S.
REQ-023 WAIT_S: on imem_rvalid_i with kill=1, discard data, clear kill, -> REQ_S.
REQ-024 VALID_S: instr_valid_o=1; instr_o and pc_o held while stall_i=1.
REQ-025 VALID_S with stall_i=0 (advance): pc_o <= br_sel_i ? {alu_data_i[31:2],2'b00} : pc_four_i; -> REQ_S.
REQ-026 instr_valid_o SHALL be 1 only in VALID_S; registered, first asserted the cycle after rvalid.
REQ-027 Minimum throughput: 3 cycles per instruction (REQ_S gnt, WAIT_S rvalid, VALID_S advance).
REQ-028 flush_i, highest priority, any state: pc_o <= {flush_pc_i[31:2],2'b00} next cycle.
REQ-029 flush_i in RST_S or VALID_S -> REQ_S; in REQ_S without gnt -> stay REQ_S with new address.
REQ-030 flush_i in REQ_S with gnt, or in WAIT_S without rvalid -> WAIT_S, kill set.
REQ-031 flush_i in WAIT_S with rvalid -> data discarded, kill cleared, -> REQ_S.
REQ-032 flush_i overrides br_sel_i/stall_i in VALID_S.
REQ-033 misalign_o SHALL pulse the cycle after a flush or taken-branch target with bits [1:0] != 0.
REQ-034 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 via pc_four_i.
REQ-035 imem_rvalid_i outside WAIT_S SHALL be ignored.

Reset
REQ-036 rst_ni=0 SHALL immediately force: state RST_S, pc_o=RESET_PC, instr_o=0, instr_valid_o=0, imem_req_o=0, misalign_o=0, kill=0.
REQ-037 Reset mid-transaction SHALL abandon any outstanding request; no data captured post-reset until a new REQ_S grant.

Verification
REQ-038 Reset release, gnt=1, rvalid next cycle, rdata=32'h0000_0013, stall=0 -> addr 0 fetched, instr_valid_o=1 one cycle, next imem_addr_o=32'h4.
REQ-039 VALID_S, br_sel_i=1, alu_data_i=32'h0000_0102 -> pc_o=32'h100, misalign_o pulses once.
REQ-040 VALID_S, stall_i=1 for 5 cycles -> instr_o, pc_o, instr_valid_o unchanged; advance on 6th.
REQ-041 flush_i in WAIT_S, flush_pc_i=32'h80 -> stale rdata dropped, next request addr 32'h80, instr_valid_o stays 0 until new data.
REQ-042 gnt withheld 4 cycles in REQ_S -> imem_req_o=1, imem_addr_o stable throughout.
REQ-043 rst_ni low during WAIT_S, then rvalid arrives -> ignored; outputs at reset values; fetch restarts at RESET_PC.
